loba_dot_acc: RTL and testbench

LOBA_DOT_ACC -- requirements
Module: loba_dot_acc

---
 rtl/loba_dot_acc_pkg.sv | 17 +
 rtl/loba_dot_acc_add.sv | 19 +
 rtl/loba_dot_acc.sv | 120 ++++++++++++
 tb/tb_loba_dot_acc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loba_dot_acc_pkg.sv
// Shared definitions for the LOBA multiplier family: default datapath widths
// and the dot-product accumulator state encoding.
package loba_dot_acc_pkg;

  // Default widths shared with the LOBA3 multiplier top level
  localparam int LOBA_P_W   = 32;
  localparam int LOBA_ACC_W = 40;
  localparam int LOBA_CNT_W = 16;

  // Accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/loba_dot_acc_add.sv
// Combinational ACC_W-bit adder used by the dot-product accumulator.
// The carry-out is what feeds the sticky overflow flag.
module loba_acc_add
  import loba_dot_acc_pkg::*;
#(
  parameter int ACC_W = LOBA_ACC_W
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  // One extra bit on the operands captures the carry-out of the top bit
  always_comb begin
    {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
  end

endmodule

// File: rtl/loba_dot_acc.sv
// Dot-product accumulator: sums the unsigned products of one vector, counts
// the terms (saturating) and flags any carry out of the accumulator, then
// holds the result until the downstream side takes it.
module loba_dot_acc
  import loba_dot_acc_pkg::*;
#(
  parameter int P_W   = LOBA_P_W,
  parameter int ACC_W = LOBA_ACC_W,
  parameter int CNT_W = LOBA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_e       r_state;
  acc_state_e       w_nextState;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] w_pExt;
  logic [ACC_W-1:0] w_addSum;
  logic             w_addCarry;
  logic             w_accept;
  logic [CNT_W-1:0] w_cntInc;

  assign w_pExt   = ACC_W'(in_p);
  assign w_accept = in_valid && in_ready;
  assign w_cntInc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  loba_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a     (r_acc),
    .i_b     (w_pExt),
    .o_sum   (w_addSum),
    .o_carry (w_addCarry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is applied
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !rst;
        if (w_accept) begin
          w_nextState = in_last ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = !rst;
        if (w_accept && in_last) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Accumulator, term counter and sticky overflow; first beat of a vector reloads them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_acc <= w_pExt;
        r_cnt <= CNT_W'(1);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_addSum;
        r_cnt <= w_cntInc;
        r_ovf <= r_ovf | w_addCarry;
      end
    end
  end

  // Result is only presented while valid, so outputs read zero before the first result
  always_comb begin
    out_sum = '0;
    out_cnt = '0;
    out_ovf = 1'b0;
    if (out_valid) begin
      out_sum = r_acc;
      out_cnt = r_cnt;
      out_ovf = r_ovf;
    end
  end

endmodule

// File: tb/tb_loba_dot_acc.sv
// Self-checking bench for loba_dot_acc: a default-width instance and a narrow
// instance (ACC_W=32, CNT_W=2) share one stimulus stream; expected results come
// from a term list summed with plain 64-bit arithmetic.
module tb_loba_dot_acc;

  localparam int A_ACC_W = 40;
  localparam int A_CNT_W = 16;
  localparam int B_ACC_W = 32;
  localparam int B_CNT_W = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_p;
  logic        in_last;
  logic        out_ready;

  logic                inReadyA, outValidA, outOvfA;
  logic [A_ACC_W-1:0]  outSumA;
  logic [A_CNT_W-1:0]  outCntA;
  logic                inReadyB, outValidB, outOvfB;
  logic [B_ACC_W-1:0]  outSumB;
  logic [B_CNT_W-1:0]  outCntB;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  int unsigned terms[$];
  bit          inVector;

  loba_dot_acc dutA (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (inReadyA),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (outValidA),
    .out_ready (out_ready),
    .out_sum   (outSumA),
    .out_cnt   (outCntA),
    .out_ovf   (outOvfA)
  );

  loba_dot_acc #(
    .P_W   (32),
    .ACC_W (B_ACC_W),
    .CNT_W (B_CNT_W)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (inReadyB),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (outValidB),
    .out_ready (out_ready),
    .out_sum   (outSumB),
    .out_cnt   (outCntB),
    .out_ovf   (outOvfB)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global timeout");
  end

  // Reference model: exact sum of the current vector's terms
  function automatic logic [63:0] modelFull();
    logic [63:0] s = 64'd0;
    foreach (terms[i]) s += 64'(terms[i]);
    return s;
  endfunction

  function automatic logic [63:0] modelSum(input int accW);
    return modelFull() & ((64'd1 << accW) - 64'd1);
  endfunction

  function automatic logic [63:0] modelOvf(input int accW);
    return ((modelFull() >> accW) != 64'd0) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] modelCnt(input int cntW);
    longint maxCnt = (longint'(1) << cntW) - 1;
    longint n = longint'(terms.size());
    return (n > maxCnt) ? 64'(maxCnt) : 64'(n);
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Full result comparison on both instances
  task automatic checkResult(input string tag);
    checkOutput({tag, "_validA"}, 64'(outValidA), 64'd1);
    checkOutput({tag, "_validB"}, 64'(outValidB), 64'd1);
    checkOutput({tag, "_sumA"},   64'(outSumA),   modelSum(A_ACC_W));
    checkOutput({tag, "_sumB"},   64'(outSumB),   modelSum(B_ACC_W));
    checkOutput({tag, "_cntA"},   64'(outCntA),   modelCnt(A_CNT_W));
    checkOutput({tag, "_cntB"},   64'(outCntB),   modelCnt(B_CNT_W));
    checkOutput({tag, "_ovfA"},   64'(outOvfA),   modelOvf(A_ACC_W));
    checkOutput({tag, "_ovfB"},   64'(outOvfB),   modelOvf(B_ACC_W));
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    stepClock();
    checkOutput({tag, "_rdyA"},   64'(inReadyA),  64'd0);
    checkOutput({tag, "_rdyB"},   64'(inReadyB),  64'd0);
    checkOutput({tag, "_validA"}, 64'(outValidA), 64'd0);
    checkOutput({tag, "_validB"}, 64'(outValidB), 64'd0);
    checkOutput({tag, "_sumA"},   64'(outSumA),   64'd0);
    checkOutput({tag, "_cntB"},   64'(outCntB),   64'd0);
    checkOutput({tag, "_ovfB"},   64'(outOvfB),   64'd0);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_rdyAfter"}, 64'(inReadyA), 64'd1);
    inVector = 1'b0;
    terms.delete();
  endtask

  // Idle gap cycles carrying junk data, then one beat held until accepted
  task automatic applyStimulus(input logic [31:0] p, input bit last, input int gap);
    int waited = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_p     = $urandom;
      in_last  = 1'($urandom);
      stepClock();
    end
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    while (!inReadyA && waited < 20) begin
      stepClock();
      waited++;
    end
    if (waited >= 20) begin
      checkOutput("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      checkOutput("beat_rdyB", 64'(inReadyB), 64'd1);
      if (!inVector) terms.delete();
      terms.push_back(p);
      inVector = !last;
      stepClock();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result check right after the last beat, optional back-pressure, then transfer
  task automatic receiveResult(input string tag, input int holdCycles);
    checkResult(tag);
    checkOutput({tag, "_rdyDone"}, 64'(inReadyA), 64'd0);
    out_ready = 1'b0;
    repeat (holdCycles) begin
      in_valid = 1'b1;
      in_p     = $urandom;
      in_last  = 1'($urandom);
      stepClock();
      checkOutput({tag, "_holdRdy"}, 64'(inReadyA), 64'd0);
      checkOutput({tag, "_holdSumA"}, 64'(outSumA), modelSum(A_ACC_W));
      checkOutput({tag, "_holdCntB"}, 64'(outCntB), modelCnt(B_CNT_W));
      checkOutput({tag, "_holdValid"}, 64'(outValidB), 64'd1);
    end
    out_ready = 1'b1;
    stepClock();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_postValid"}, 64'(outValidA), 64'd0);
    checkOutput({tag, "_postRdy"},   64'(inReadyB),  64'd1);
  endtask

  // Directed scenarios followed by randomized vectors
  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    inVector  = 1'b0;
    stepClock();
    doReset("reset");

    // Three-term vector with out_ready held high
    out_ready = 1'b1;
    applyStimulus(32'd100, 1'b0, 0);
    applyStimulus(32'd200, 1'b0, 0);
    applyStimulus(32'd300, 1'b1, 0);
    receiveResult("three_terms", 0);

    // Single all-ones term
    applyStimulus(32'hFFFF_FFFF, 1'b1, 0);
    receiveResult("single_max", 0);

    // Carry out of a 32-bit accumulator, then overflow cleared by next vector
    applyStimulus(32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus(32'd2, 1'b1, 0);
    receiveResult("carry", 0);
    applyStimulus(32'd5, 1'b1, 0);
    receiveResult("ovf_clear", 0);

    // Back-pressure for 10 cycles with in_valid high
    applyStimulus(32'd11, 1'b0, 0);
    applyStimulus(32'd22, 1'b0, 1);
    applyStimulus(32'd33, 1'b1, 2);
    receiveResult("backpressure", 10);

    // Reset in the middle of a vector
    applyStimulus(32'd10, 1'b0, 0);
    applyStimulus(32'd20, 1'b0, 0);
    doReset("mid_reset");
    applyStimulus(32'd7, 1'b1, 0);
    receiveResult("after_reset", 0);

    // Five terms of one: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) applyStimulus(32'd1, (i == 4), 0);
    receiveResult("cnt_sat", 0);

    // Randomized vectors with gaps and random back-pressure
    for (int v = 0; v < 8; v++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        applyStimulus($urandom, (i == len - 1), $urandom_range(0, 2));
      end
      receiveResult("random", $urandom_range(0, 3));
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
